// File: rtl/game_pkg.sv
// Shared types and sizing for the Mastermind game controller.
package game_pkg;
  localparam int unsigned DIGITS    = 4;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned WIN_COUNT = 4;
  localparam int unsigned ATTEMPT_W = 4;
  localparam int unsigned GUESS_W   = DIGITS * NIBBLE_W;
  localparam int unsigned COUNT_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    WAIT,
    EVAL,
    WON,
    LOST
  } state_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] correct;
    logic [NIBBLE_W-1:0] wrong;
  } result_t;
endpackage

// File: rtl/guess_entry_buffer.sv
// Assembles a 4-nibble guess from keypad strobes; first digit lands in nibble 3.
// UNIQUE_DIGITS_EN refuses a digit already present in the partial guess.
module guess_entry_buffer
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                digit_valid,
  input  logic [NIBBLE_W-1:0] digit_in,
  output logic [GUESS_W-1:0]  guess,
  output logic [COUNT_W-1:0]  digit_count,
  output logic                digit_reject,
  output logic                full_c
);
  logic dup_c;
  logic accept_c;

`ifdef UNIQUE_DIGITS_EN
  // Entered digits occupy the low digit_count nibbles.
  always_comb begin
    dup_c = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((COUNT_W'(k) < digit_count) && (guess[k*NIBBLE_W +: NIBBLE_W] == digit_in))
        dup_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_reject <= 1'b0;
    else       digit_reject <= enable && digit_valid && !clear && dup_c;
  end
`else
  assign dup_c        = 1'b0;
  assign digit_reject = 1'b0;
`endif

  // Clear has priority over a simultaneous digit.
  assign accept_c = enable && digit_valid && !clear && !dup_c &&
                    (digit_count < COUNT_W'(DIGITS));
  assign full_c   = accept_c && (digit_count == COUNT_W'(DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess       <= '0;
      digit_count <= '0;
    end else if (clear) begin
      guess       <= '0;
      digit_count <= '0;
    end else if (accept_c) begin
      guess       <= {guess[GUESS_W-NIBBLE_W-1:0], digit_in};
      digit_count <= digit_count + COUNT_W'(1);
    end
  end
endmodule

// File: rtl/mastermind_game_ctrl.sv
// Sequences one Mastermind round around an external guess_checker.
// Build option UNIQUE_DIGITS_EN (in guess_entry_buffer) refuses repeated digits.
module mastermind_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 secret_load,
  input  logic [GUESS_W-1:0]   secret_in,
  input  logic                 start,
  input  logic                 digit_valid,
  input  logic [NIBBLE_W-1:0]  digit_in,
  input  logic                 digit_clear,
  output logic [GUESS_W-1:0]   chk_secret,
  output logic [GUESS_W-1:0]   chk_guess,
  input  logic [NIBBLE_W-1:0]  chk_correct,
  input  logic [NIBBLE_W-1:0]  chk_wrong,
  output logic [COUNT_W-1:0]   digit_count,
  output logic                 digit_reject,
  output logic                 result_valid,
  output logic [NIBBLE_W-1:0]  result_correct,
  output logic [NIBBLE_W-1:0]  result_wrong,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic                 win,
  output logic                 lose,
  output logic                 busy
);
  state_t                state, state_next;
  result_t               result_q, result_d;
  logic [GUESS_W-1:0]    chk_secret_d;
  logic [ATTEMPT_W-1:0]  attempts_d;
  logic                  result_valid_d, win_d, lose_d, busy_d;
  logic                  idle_like_c, start_ok_c, buf_clear_c, full_c;
  logic [ATTEMPT_W-1:0]  attempts_inc_c;

  assign idle_like_c    = (state == IDLE) || (state == WON) || (state == LOST);
  assign start_ok_c     = idle_like_c && start;
  assign attempts_inc_c = attempts + ATTEMPT_W'(1);
  // Guess buffer is emptied on a new game, after every evaluation, and on keypad clear.
  assign buf_clear_c    = start_ok_c || (state == EVAL) || ((state == ENTRY) && digit_clear);

  guess_entry_buffer u_entry (
    .clk          (clk),
    .reset        (reset),
    .enable       (state == ENTRY),
    .clear        (buf_clear_c),
    .digit_valid  (digit_valid),
    .digit_in     (digit_in),
    .guess        (chk_guess),
    .digit_count  (digit_count),
    .digit_reject (digit_reject),
    .full_c       (full_c)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      chk_secret   <= '0;
      result_q     <= '0;
      attempts     <= '0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      chk_secret   <= chk_secret_d;
      result_q     <= result_d;
      attempts     <= attempts_d;
      result_valid <= result_valid_d;
      win          <= win_d;
      lose         <= lose_d;
      busy         <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WON, LOST: if (start) state_next = ENTRY;
      ENTRY:           if (full_c) state_next = WAIT;
      WAIT:            state_next = EVAL;
      EVAL: begin
        if (chk_correct == NIBBLE_W'(WIN_COUNT))              state_next = WON;
        else if (attempts_inc_c == ATTEMPT_W'(MAX_ATTEMPTS)) state_next = LOST;
        else                                                  state_next = ENTRY;
      end
      default:         state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    chk_secret_d   = chk_secret;
    result_d       = result_q;
    attempts_d     = attempts;
    result_valid_d = 1'b0;
    win_d          = (state_next == WON);
    lose_d         = (state_next == LOST);
    busy_d         = (state_next == WAIT) || (state_next == EVAL);
    if (idle_like_c && secret_load) chk_secret_d = secret_in;
    if (start_ok_c) begin
      result_d   = '0;
      attempts_d = '0;
    end
    if (state == EVAL) begin
      result_d.correct = chk_correct;
      result_d.wrong   = chk_wrong;
      attempts_d       = attempts_inc_c;
      result_valid_d   = 1'b1;
    end
  end

  assign result_correct = result_q.correct;
  assign result_wrong   = result_q.wrong;
endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed + randomized bench for mastermind_game_ctrl with a behavioural checker and game model.
module tb_mastermind_game_ctrl;
  localparam int unsigned MAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        secret_load = 1'b0;
  logic [15:0] secret_in = '0;
  logic        start = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        digit_clear = 1'b0;
  logic [15:0] chk_secret, chk_guess;
  logic [3:0]  chk_correct, chk_wrong;
  logic [2:0]  digit_count;
  logic        digit_reject, result_valid, win, lose, busy;
  logic [3:0]  result_correct, result_wrong, attempts;

  int checks = 0;
  int errors = 0;

  // Game model
  logic [15:0] m_secret = '0;
  logic [3:0]  m_q[$];
  bit          m_playing = 0;
  int          m_att = 0;
  bit          m_win = 0, m_lose = 0;
  logic [3:0]  m_rc = '0, m_rw = '0;

  mastermind_game_ctrl #(.MAX_ATTEMPTS(MAX)) dut (
    .clk(clk), .reset(reset), .secret_load(secret_load), .secret_in(secret_in),
    .start(start), .digit_valid(digit_valid), .digit_in(digit_in), .digit_clear(digit_clear),
    .chk_secret(chk_secret), .chk_guess(chk_guess), .chk_correct(chk_correct), .chk_wrong(chk_wrong),
    .digit_count(digit_count), .digit_reject(digit_reject), .result_valid(result_valid),
    .result_correct(result_correct), .result_wrong(result_wrong), .attempts(attempts),
    .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] n_correct(input logic [15:0] s, input logic [15:0] g);
    int n = 0;
    for (int i = 0; i < 4; i++) if (s[4*i +: 4] == g[4*i +: 4]) n++;
    return 4'(n);
  endfunction

  function automatic logic [3:0] n_wrong(input logic [15:0] s, input logic [15:0] g);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      bit found = 0;
      if (s[4*i +: 4] != g[4*i +: 4])
        for (int j = 0; j < 4; j++) if (j != i && s[4*j +: 4] == g[4*i +: 4]) found = 1;
      if (found) n++;
    end
    return 4'(n);
  endfunction

  // Stand-in guess_checker: registered counts, one cycle latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_correct <= '0;
      chk_wrong   <= '0;
    end else begin
      chk_correct <= n_correct(chk_secret, chk_guess);
      chk_wrong   <= n_wrong(chk_secret, chk_guess);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_secret"}, 32'(chk_secret), 32'(m_secret));
    check({tag, "_att"}, 32'(attempts), 32'(m_att));
    check({tag, "_win"}, 32'(win), 32'(m_win));
    check({tag, "_lose"}, 32'(lose), 32'(m_lose));
    check({tag, "_rc"}, 32'(result_correct), 32'(m_rc));
    check({tag, "_rw"}, 32'(result_wrong), 32'(m_rw));
  endtask

  task automatic do_start(input bit load, input logic [15:0] sec);
    start = 1; secret_load = load; secret_in = sec;
    tick();
    start = 0; secret_load = 0;
    if (!m_playing) begin
      if (load) m_secret = sec;
      m_playing = 1; m_att = 0; m_win = 0; m_lose = 0; m_rc = '0; m_rw = '0;
      m_q.delete();
    end
    check_state("start");
    check("start_cnt", 32'(digit_count), 32'(m_q.size()));
  endtask

  task automatic load_only(input logic [15:0] sec);
    secret_load = 1; secret_in = sec;
    tick();
    secret_load = 0;
    if (!m_playing) m_secret = sec;
    check("load_secret", 32'(chk_secret), 32'(m_secret));
  endtask

  task automatic key(input logic [3:0] d, input bit clr);
    bit exp_rej = 0;
    bit dup = 0;
    digit_valid = 1; digit_in = d; digit_clear = clr;
    tick();
    digit_valid = 0; digit_clear = 0;
    if (m_playing) begin
      foreach (m_q[i]) if (m_q[i] == d) dup = 1;
`ifndef UNIQUE_DIGITS_EN
      dup = 0;
`endif
      if (clr)      m_q.delete();
      else if (dup) exp_rej = 1;
      else          m_q.push_back(d);
    end
    check("reject", 32'(digit_reject), 32'(exp_rej));
    check("count", 32'(digit_count), 32'(m_q.size()));
  endtask

  task automatic finish_guess();
    logic [15:0] g;
    logic [3:0]  ec, ew;
    g = {m_q[0], m_q[1], m_q[2], m_q[3]};
    check("busy_wait", 32'(busy), 1);
    check("guess_wait", 32'(chk_guess), 32'(g));
    tick();
    check("rv_eval", 32'(result_valid), 0);
    check("busy_eval", 32'(busy), 1);
    tick();
    ec = n_correct(m_secret, g);
    ew = n_wrong(m_secret, g);
    m_att++;
    m_rc = ec; m_rw = ew;
    m_win = (ec == 4);
    m_lose = !m_win && (m_att == int'(MAX));
    if (m_win || m_lose) m_playing = 0;
    m_q.delete();
    check("rv_pulse", 32'(result_valid), 1);
    check("busy_done", 32'(busy), 0);
    check_state("result");
    tick();
    check("rv_end", 32'(result_valid), 0);
  endtask

  task automatic play(input logic [15:0] g);
    for (int i = 3; i >= 0; i--) begin
      key(g[4*i +: 4], 0);
      if (m_q.size() == 4) finish_guess();
    end
  endtask

  initial begin
    #12;
    check("rst_secret", 32'(chk_secret), 0);
    check("rst_guess", 32'(chk_guess), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rv", 32'(result_valid), 0);
    @(negedge clk); reset = 0;
    tick();

    // Win on first guess
    do_start(1, 16'h1234);
    play(16'h1234);
    // Permuted guess, reusing the secret
    do_start(0, 16'h0);
    play(16'h4321);
    // Secret load during a game is ignored
    load_only(16'hABCD);
    // Loss after MAX guesses
    play(16'h5678);
    play(16'h5678);
    check("lost", 32'(lose), 1);
    key(4'h1, 0);
    do_start(0, 16'h0);
    // Clear beats a simultaneous digit
    key(4'h9, 0); key(4'h9, 0); key(4'h7, 1);
    play(16'h1234);
    // Duplicate digits
    do_start(0, 16'h0);
    key(4'h1, 0); key(4'h1, 0);
    tick();
    check("reject_once", 32'(digit_reject), 0);
    key(4'h0, 1);
    // Load in IDLE-like state without start, then start
    load_only(16'h0F0F);
    do_start(0, 16'h0);
    play(16'h0F0F);

    // Randomized games
    for (int gidx = 0; gidx < 8; gidx++) begin
      int budget = 0;
      do_start(($urandom % 2) == 0 || gidx == 0, 16'($urandom));
      while (m_playing && budget < 200) begin
        logic [3:0] d;
        int sz;
        sz = m_q.size();
        d = ($urandom % 2 == 0) ? m_secret[4*(3-sz) +: 4] : 4'($urandom);
        key(d, ($urandom % 16) == 0);
        if (m_q.size() == 4) finish_guess();
        budget++;
      end
      check("game_budget", 32'(m_playing), 0);
    end

    // Reset in WAIT
    do_start(1, 16'h2468);
    key(4'h2, 0); key(4'h4, 0); key(4'h6, 0); key(4'h8, 0);
    check("in_wait", 32'(busy), 1);
    #2 reset = 1;
    #1;
    m_secret = '0; m_playing = 0; m_att = 0; m_win = 0; m_lose = 0;
    m_rc = '0; m_rw = '0; m_q.delete();
    check_state("rst_mid");
    check("rst_mid_guess", 32'(chk_guess), 0);
    check("rst_mid_cnt", 32'(digit_count), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rej", 32'(digit_reject), 0);
    check("rst_mid_rv", 32'(result_valid), 0);
    @(negedge clk); reset = 0;
    key(4'h5, 0);
    check("idle_guess", 32'(chk_guess), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mastermind_game_ctrl.md
# mastermind_game_ctrl

- Sequences one Mastermind round around the existing 4-digit `guess_checker`.
- Holds the secret and assembles a 4-nibble guess from keypad digit strobes.
- Presents the secret and guess to the checker, samples its registered counts after the checker's one-cycle latency, and tracks attempts.
- Declares a win or a loss; sits between the keypad/debounce front end and the display/score logic.

## Interface
- MAX_ATTEMPTS, default 10: guesses allowed per game; legal range 1..15.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- secret_load  in  1  load secret_in; honoured only in IDLE, WON or LOST.
- secret_in  in  16  four hex digits; nibble 3 is the leftmost.
- start  in  1  begin a game; honoured in IDLE, WON or LOST.
- digit_valid  in  1  one-cycle keypad strobe.
- digit_in  in  4  digit value, qualified by digit_valid.
- digit_clear  in  1  discard the partial guess.
- chk_secret  out  16  to checker secret_number; registered.
- chk_guess  out  16  to checker guess; registered.
- chk_correct  in  4  from checker correct_place_count.
- chk_wrong  in  4  from checker wrong_place_count.
- digit_count  out  3  digits entered in the current guess, 0..4.
- digit_reject  out  1  one-cycle pulse when an entered digit is refused.
- result_valid  out  1  one-cycle pulse when a new result is available.
- result_correct  out  4  latched correct-place count.
- result_wrong  out  4  latched wrong-place count.
- attempts  out  4  guesses evaluated in this game.
- win  out  1  level, high in WON.
- lose  out  1  level, high in LOST.
- busy  out  1  high in WAIT or EVAL.

## Operation
- Reset: state IDLE; every output and internal register is 0.
- States:
  - IDLE:
    - secret_load latches secret_in into chk_secret.
    - start goes to ENTRY with attempts=0, digit_count=0, chk_guess=0.
  - ENTRY:
    - An accepted digit does chk_guess <= {chk_guess[11:0], digit_in} and increments digit_count.
    - Accepting the 4th digit moves to WAIT.
  - WAIT: a single cycle in which the checker samples chk_secret and chk_guess.
  - EVAL: a single cycle.
    - Latch chk_correct and chk_wrong into the result registers.
    - Increment attempts and pulse result_valid next cycle.
    - Next state:
      - WON if chk_correct==4.
      - Otherwise LOST if the new attempts value equals MAX_ATTEMPTS.
      - Otherwise ENTRY, with digit_count=0 and chk_guess=0.
  - WON/LOST:
    - Hold results, attempts and win/lose.
    - start goes to ENTRY, reusing chk_secret and clearing attempts, results, win and lose.
- digit_clear in ENTRY zeroes chk_guess and digit_count.
  - If digit_valid is high in the same cycle, clear wins and the digit is dropped.
- digit_valid and digit_clear are ignored outside ENTRY; no reject pulse is generated.
- secret_load in ENTRY, WAIT or EVAL is ignored.
- If secret_load and start are high in the same cycle, the new secret is loaded and the game starts with it.
- Win is decided only by chk_correct==4. chk_wrong is passed through unmodified, even when duplicate digits inflate it.
- attempts never exceeds MAX_ATTEMPTS.

## Timing
- 4th digit_valid sampled in cycle C0: C1 is WAIT, C2 is EVAL, and result_valid, results, attempts and win/lose update in C3.
- A new digit is accepted in C3 at the earliest.
- result_valid lasts exactly one cycle per evaluated guess.
- chk_guess is stable from the end of C0 through C2.
- reset mid-round (any state) returns to IDLE asynchronously. The secret is lost and the checker is reset by the same signal.

## Configuration
- UNIQUE_DIGITS_EN defined:
  - In ENTRY, a digit equal to any already-entered nibble of the current guess is refused.
  - A refused digit pulses digit_reject in the following cycle and leaves chk_guess and digit_count unchanged.
- Undefined: duplicates are accepted and digit_reject is tied to 0.

## Structure
- Package game_pkg holds:
  - the state enum (IDLE, ENTRY, WAIT, EVAL, WON, LOST);
  - DIGITS=4, NIBBLE_W=4, WIN_COUNT=4, ATTEMPT_W=4.
- One sub-module, guess_entry_buffer, contains:
  - the shift register, digit_count and clear;
  - the duplicate compare under UNIQUE_DIGITS_EN;
  - a full flag to the FSM.
- guess_checker is instantiated beside this block at the game top, not inside it.

## Test plan
- Win on first guess:
  - Stimulus: secret 0x1234, start, digits 1,2,3,4.
  - Response: result_valid 3 cycles after the last digit; correct=4, wrong=0, win=1, attempts=1.
- Permuted guess:
  - Stimulus: secret 0x1234, digits 4,3,2,1.
  - Response: correct=0, wrong=4, attempts=1, back in ENTRY with digit_count=0.
- Loss:
  - Stimulus: MAX_ATTEMPTS=3, secret 0x1234, three guesses of 5,6,7,8.
  - Response: third result has lose=1 and attempts=3. A further digit_valid leaves digit_count at 0. start then clears attempts to 0 and returns to ENTRY.
- Clear:
  - Stimulus: digits 9,9, digit_clear together with digit_valid 7, then 1,2,3,4.
  - Response: chk_guess=0x1234 in WAIT, correct=4.
- Reset mid-round:
  - Stimulus: reset in WAIT.
  - Response: all outputs 0 immediately, state IDLE, following digit_valid ignored.
- UNIQUE_DIGITS_EN:
  - Stimulus: digits 1,1.
  - Response with macro: digit_reject pulses once and digit_count stays 1. Response without macro: digit_count=2 and no reject.
